// File: rtl/spi_slave_rx_pkg.sv
// Shared types for the SPI slave receiver: FSM state encoding and SPI mode constants.
package spi_slave_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Mode encodings as {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus the host-side tx/rx handshakes of the SPI slave receiver.
interface spi_slave_rx_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_load, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_load, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );
endinterface

// File: rtl/spi_slave_rx_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin with rise/fall detection
// against a one-cycle-delayed copy of the synchronised level.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave endpoint: oversampled pins, MSB-first rx deserialiser with one-deep holding
// register and valid/ready handshake, tx buffer shifted out on miso in the same frame.
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_rx_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_cs_s, w_cs_rise, w_cs_fall;
  logic w_mosi_s, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_sclk_s_unused, w_cs_s_unused;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_pin(bus.sclk),
    .o_sync(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_pin(bus.cs_n),
    .o_sync(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_pin(bus.mosi),
    .o_sync(w_mosi_s), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  assign w_sclk_s_unused = w_sclk_s;
  assign w_cs_s_unused   = w_cs_s;

  // Leading edge leaves the idle level; CPHA picks which edge samples and which shifts.
  logic w_lead, w_trail, w_sample, w_shift;
  assign w_lead   = (CPOL != 0) ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = (CPOL != 0) ? w_sclk_rise : w_sclk_fall;
  assign w_sample = (CPHA != 0) ? w_trail : w_lead;
  assign w_shift  = (CPHA != 0) ? w_lead  : w_trail;

  state_t r_state, w_state_nxt;
  logic   w_in_load, w_in_shift, w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_cs_fall) w_state_nxt = LOAD;
        LOAD:    w_state_nxt = SHIFT;
        SHIFT:   w_state_nxt = SHIFT;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_in_load  = (r_state == LOAD)  && !w_cs_rise;
    w_in_shift = (r_state == SHIFT) && !w_cs_rise;
    w_busy     = (r_state != IDLE);
  end

  logic [DATA_W-1:0] r_tx_buf, r_tx_shift, r_rx_shift, r_rx_data;
  logic              r_tx_full, r_rx_valid, r_overrun, r_word_done, r_miso, r_miso_oe;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] w_tx_word;
  logic              w_reload, w_take;

  assign w_tx_word = r_tx_full ? r_tx_buf : '0;
  assign w_reload  = r_word_done && w_in_shift;
  assign w_take    = w_in_load || w_reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_buf    <= '0;
      r_tx_full   <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_word_done <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      r_overrun   <= 1'b0;
      r_word_done <= 1'b0;

      // Buffer is consumed before a same-cycle tx_load is considered.
      if (w_take) r_tx_full <= 1'b0;
      if (bus.tx_load && (!r_tx_full || w_take)) begin
        r_tx_buf  <= bus.tx_data;
        r_tx_full <= 1'b1;
      end

      if (w_cs_rise) begin
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end else if ((r_state == IDLE) && w_cs_fall) begin
        r_miso_oe <= 1'b1;
      end else if (w_in_load) begin
        r_bit_cnt <= '0;
        if (CPHA == 0) begin
          r_miso     <= w_tx_word[DATA_W-1];
          r_tx_shift <= {w_tx_word[DATA_W-2:0], 1'b0};
        end else begin
          r_tx_shift <= w_tx_word;
        end
      end else if (w_in_shift) begin
        if (r_word_done) begin
          r_bit_cnt  <= '0;
          r_tx_shift <= w_tx_word;
        end
        if (w_sample) begin
          r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
          r_bit_cnt  <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) r_word_done <= 1'b1;
        end
        if (w_shift) begin
          r_miso     <= r_tx_shift[DATA_W-1];
          r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
        end
      end

      // A completed word lands only if the holding register is free or being emptied.
      if (r_word_done) begin
        if (!r_rx_valid || bus.rx_ready) begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.miso     = r_miso;
  assign bus.miso_oe  = r_miso_oe;
  assign bus.tx_ready = ~r_tx_full;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.overrun  = r_overrun;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench: a mode-0 and a mode-3 instance driven by a bit-banged SPI master.
module tb_spi_slave_rx;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_sclk = 1'b0;
  logic m_mosi = 1'b0;
  logic cs0_n = 1'b1;
  logic cs3_n = 1'b1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_slave_rx_if #(.DATA_W(8)) if0 ();
  spi_slave_rx_if #(.DATA_W(8)) if3 ();

  assign if0.sclk = m_sclk;
  assign if0.cs_n = cs0_n;
  assign if0.mosi = m_mosi;
  assign if3.sclk = ~m_sclk;
  assign if3.cs_n = cs3_n;
  assign if3.mosi = m_mosi;

  spi_slave_rx #(.DATA_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );
  spi_slave_rx #(.DATA_W(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave)
  );

  logic [7:0] got_q[$];
  int ovr_cnt = 0;

  always @(negedge clk) begin
    if (if0.rx_valid && if0.rx_ready) got_q.push_back(if0.rx_data);
    if (if0.overrun) ovr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_start(input bit sel3);
    if (sel3) cs3_n = 1'b0;
    else      cs0_n = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_end(input bit sel3);
    tick(HALF);
    if (sel3) cs3_n = 1'b1;
    else      cs0_n = 1'b1;
    tick(HALF + 4);
  endtask

  task automatic xfer(input bit cpha1, input logic [7:0] mo, input int nbits,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha1) begin
        m_mosi = mo[i];
        tick(HALF);
        m_sclk = 1'b1;
        mi[i] = if0.miso;
        tick(HALF);
        m_sclk = 1'b0;
      end else begin
        m_sclk = 1'b1;
        m_mosi = mo[i];
        tick(HALF);
        m_sclk = 1'b0;
        mi[i] = if3.miso;
        tick(HALF);
      end
    end
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int snap_q, snap_o;

    if0.tx_data = 8'h00; if0.tx_load = 1'b0; if0.rx_ready = 1'b0;
    if3.tx_data = 8'h00; if3.tx_load = 1'b0; if3.rx_ready = 1'b0;

    tick(3);
    check("rst0_tx_ready", 32'(if0.tx_ready), 32'd1);
    check("rst0_rx_valid", 32'(if0.rx_valid), 32'd0);
    check("rst0_busy",     32'(if0.busy),     32'd0);
    check("rst0_miso_oe",  32'(if0.miso_oe),  32'd0);
    check("rst0_rx_data",  32'(if0.rx_data),  32'h00);
    check("rst3_miso",     32'(if3.miso),     32'd0);
    rst_n = 1'b1;
    tick(4);

    // Mode 0: master sends A5, slave returns 3C
    if0.tx_data = 8'h3C; if0.tx_load = 1'b1;
    tick(1);
    if0.tx_load = 1'b0;
    check("t1_tx_full", 32'(if0.tx_ready), 32'd0);
    frame_start(1'b0);
    check("t1_busy",    32'(if0.busy),    32'd1);
    check("t1_miso_oe", 32'(if0.miso_oe), 32'd1);
    xfer(1'b0, 8'hA5, 8, mi);
    frame_end(1'b0);
    check("t1_rx_valid", 32'(if0.rx_valid), 32'd1);
    check("t1_rx_data",  32'(if0.rx_data),  32'hA5);
    check("t1_miso",     32'(mi),           32'h3C);
    check("t1_tx_ready", 32'(if0.tx_ready), 32'd1);
    check("t1_idle",     32'(if0.busy),     32'd0);
    check("t1_oe_off",   32'(if0.miso_oe),  32'd0);
    if0.rx_ready = 1'b1;
    tick(1);
    if0.rx_ready = 1'b0;
    check("t1_consumed", 32'(if0.rx_valid), 32'd0);

    // Mode 3: master sends 5A, slave returns C3
    if3.tx_data = 8'hC3; if3.tx_load = 1'b1;
    tick(1);
    if3.tx_load = 1'b0;
    frame_start(1'b1);
    xfer(1'b1, 8'h5A, 8, mi);
    frame_end(1'b1);
    check("t2_rx_valid", 32'(if3.rx_valid), 32'd1);
    check("t2_rx_data",  32'(if3.rx_data),  32'h5A);
    check("t2_miso",     32'(mi),           32'hC3);
    check("t0_dut0_quiet", 32'(if0.rx_valid), 32'd0);

    // Back-to-back words, second with empty tx buffer
    if0.tx_data = 8'h96; if0.tx_load = 1'b1;
    tick(1);
    if0.tx_load = 1'b0;
    if0.rx_ready = 1'b1;
    snap_q = got_q.size();
    frame_start(1'b0);
    xfer(1'b0, 8'h11, 8, mi);
    xfer(1'b0, 8'h22, 8, mi2);
    frame_end(1'b0);
    check("t3_count", 32'(got_q.size() - snap_q), 32'd2);
    if (got_q.size() >= snap_q + 2) begin
      check("t3_word1", 32'(got_q[snap_q]),     32'h11);
      check("t3_word2", 32'(got_q[snap_q + 1]), 32'h22);
    end
    check("t3_miso1", 32'(mi),  32'h96);
    check("t3_miso2", 32'(mi2), 32'h00);

    // Overrun: rx_ready low, two words
    if0.rx_ready = 1'b0;
    snap_o = ovr_cnt;
    frame_start(1'b0);
    xfer(1'b0, 8'h80, 8, mi);
    xfer(1'b0, 8'hFF, 8, mi);
    frame_end(1'b0);
    check("t4_rx_data",  32'(if0.rx_data),  32'h80);
    check("t4_rx_valid", 32'(if0.rx_valid), 32'd1);
    check("t4_overrun",  32'(ovr_cnt - snap_o), 32'd1);
    if0.rx_ready = 1'b1;
    tick(1);
    check("t4_drained", 32'(if0.rx_valid), 32'd0);

    // cs_n rise mid-word discards the partial word
    snap_q = got_q.size();
    snap_o = ovr_cnt;
    frame_start(1'b0);
    xfer(1'b0, 8'hF0, 5, mi);
    frame_end(1'b0);
    check("t5_partial_none", 32'(got_q.size() - snap_q), 32'd0);
    frame_start(1'b0);
    xfer(1'b0, 8'h0F, 8, mi);
    frame_end(1'b0);
    check("t5_count", 32'(got_q.size() - snap_q), 32'd1);
    if (got_q.size() >= snap_q + 1)
      check("t5_word", 32'(got_q[snap_q]), 32'h0F);
    check("t5_no_overrun", 32'(ovr_cnt - snap_o), 32'd0);
    check("t5_rx_data", 32'(if0.rx_data), 32'h0F);
    if0.rx_ready = 1'b0;

    // Asynchronous reset in the middle of a word
    if0.tx_data = 8'h12; if0.tx_load = 1'b1;
    tick(1);
    if0.tx_load = 1'b0;
    frame_start(1'b0);
    if0.tx_data = 8'h34; if0.tx_load = 1'b1;
    tick(1);
    if0.tx_load = 1'b0;
    check("t6_pre_busy", 32'(if0.busy),     32'd1);
    check("t6_pre_full", 32'(if0.tx_ready), 32'd0);
    xfer(1'b0, 8'hAA, 3, mi);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy",     32'(if0.busy),     32'd0);
    check("t6_miso_oe",  32'(if0.miso_oe),  32'd0);
    check("t6_miso",     32'(if0.miso),     32'd0);
    check("t6_tx_ready", 32'(if0.tx_ready), 32'd1);
    check("t6_rx_valid", 32'(if0.rx_valid), 32'd0);
    check("t6_rx_data",  32'(if0.rx_data),  32'h00);
    check("t6_overrun",  32'(if0.overrun),  32'd0);
    tick(1);
    cs0_n = 1'b1;
    m_sclk = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    frame_start(1'b0);
    xfer(1'b0, 8'h55, 8, mi);
    frame_end(1'b0);
    check("t6_rx_valid_after", 32'(if0.rx_valid), 32'd1);
    check("t6_rx_data_after",  32'(if0.rx_data),  32'h55);
    check("t6_miso_after",     32'(mi),           32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
